// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the I/O page responder.
//   - Byte offsets of the four word registers in the I/O page.
//   - Bit positions inside the STATUS register.
//   - Width of the debounce threshold / counter.
//   - Word-select enum and a byte-lane merge helper.
package io_pkg;

    localparam int unsigned DB_W = 16;

    localparam logic [3:0] IO_LED      = 4'h0;
    localparam logic [3:0] IO_STATUS   = 4'h4;
    localparam logic [3:0] IO_TIMER    = 4'h8;
    localparam logic [3:0] IO_DEBOUNCE = 4'hC;

    localparam int unsigned ST_LEVEL = 0;
    localparam int unsigned ST_RISE  = 1;
    localparam int unsigned ST_FALL  = 2;

    // Word index within the page, i.e. io_addr[3:2].
    typedef enum logic [1:0] {
        REG_LED      = 2'd0,
        REG_STATUS   = 2'd1,
        REG_TIMER    = 2'd2,
        REG_DEBOUNCE = 2'd3
    } io_reg_e;

    // Replace each byte of old_v whose mask bit is set with the matching byte of new_v.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  mask);
        logic [31:0] r;
        r = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_debouncer.sv
// sw_debouncer: two-flop synchroniser followed by a counting debouncer.
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   sw_i      raw asynchronous switch input
//   thresh_i  debounce threshold in cycles (0 behaves as 1)
//   level_o   debounced level
//   rise_o    one-cycle pulse, asserted in the cycle level_o goes 0->1 on the next edge
//   fall_o    one-cycle pulse, asserted in the cycle level_o goes 1->0 on the next edge
module sw_debouncer
    import io_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            sw_i,
    input  logic [DB_W-1:0] thresh_i,
    output logic            level_o,
    output logic            rise_o,
    output logic            fall_o
);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic [DB_W-1:0] thr_eff;
    logic [DB_W:0]   cnt_inc;
    logic            commit;

    always_comb begin
        thr_eff = (thresh_i == '0) ? DB_W'(1) : thresh_i;
        cnt_inc = {1'b0, cnt_q} + (DB_W+1)'(1);
        cnt_d   = cnt_q;
        level_d = level_q;
        commit  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_inc >= {1'b0, thr_eff}) begin
            // >= rather than == so a lowered threshold commits an in-progress count.
            commit  = 1'b1;
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_inc[DB_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = commit &  sync2_q;
    assign fall_o  = commit & ~sync2_q;

endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped I/O page responder on the CPU data bus.
// Registers: LED (0x0), STATUS (0x4, level + W1C edge flags), TIMER (0x8),
// DEBOUNCE (0xC). Every accepted access completes with a one-cycle io_ready
// pulse in the following cycle; reads return the pre-write register value.
// Ports:
//   CLK, RESETN   clock, asynchronous active-low reset
//   io_sel        access targets this page
//   io_addr       byte offset (bits [1:0] ignored)
//   io_wdata      write data
//   io_wmask      byte write enables (nonzero = write)
//   io_rstrb      read strobe
//   io_rdata      registered read data (0 for non-reads)
//   io_ready      completion pulse
//   SW            raw switch input
//   LED           LED register
module io_responder
    import io_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_DEFAULT = 16'd1000
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        io_sel,
    input  logic [3:0]  io_addr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wmask,
    input  logic        io_rstrb,
    output logic [31:0] io_rdata,
    output logic        io_ready,
    input  logic        SW,
    output logic [7:0]  LED
);

    logic [7:0]      led_q, led_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic [31:0]     timer_q, timer_d;
    logic [DB_W-1:0] thresh_q, thresh_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ready_q, ready_d;

    logic            sw_level, sw_rise, sw_fall;
    logic            wr, rd;
    io_reg_e         sel_reg;
    logic [31:0]     status_w, rd_val, thresh_merge;
    logic            unused_addr;

    assign unused_addr = ^io_addr[1:0];

    sw_debouncer u_sw_debouncer (
        .clk_i    (CLK),
        .rst_ni   (RESETN),
        .sw_i     (SW),
        .thresh_i (thresh_q),
        .level_o  (sw_level),
        .rise_o   (sw_rise),
        .fall_o   (sw_fall)
    );

    always_comb begin
        wr      = io_sel & (|io_wmask);
        rd      = io_sel & io_rstrb;
        sel_reg = io_reg_e'(io_addr[3:2]);

        status_w           = '0;
        status_w[ST_LEVEL] = sw_level;
        status_w[ST_RISE]  = rise_q;
        status_w[ST_FALL]  = fall_q;

        case (sel_reg)
            REG_LED:      rd_val = {24'b0, led_q};
            REG_STATUS:   rd_val = status_w;
            REG_TIMER:    rd_val = timer_q;
            REG_DEBOUNCE: rd_val = {{(32-DB_W){1'b0}}, thresh_q};
            default:      rd_val = '0;
        endcase

        thresh_merge = byte_merge({{(32-DB_W){1'b0}}, thresh_q}, io_wdata, {2'b00, io_wmask[1:0]});

        led_d    = led_q;
        timer_d  = timer_q + 32'd1;
        thresh_d = thresh_q;
        // A new edge event always sets its flag, even against a same-cycle W1C.
        rise_d   = rise_q | sw_rise;
        fall_d   = fall_q | sw_fall;

        if (wr) begin
            case (sel_reg)
                REG_LED: begin
                    if (io_wmask[0]) led_d = io_wdata[7:0];
                end
                REG_STATUS: begin
                    if (io_wmask[0]) begin
                        rise_d = sw_rise | (rise_q & ~io_wdata[ST_RISE]);
                        fall_d = sw_fall | (fall_q & ~io_wdata[ST_FALL]);
                    end
                end
                REG_TIMER: begin
                    timer_d = byte_merge(timer_q + 32'd1, io_wdata, io_wmask);
                end
                REG_DEBOUNCE: begin
                    thresh_d = thresh_merge[DB_W-1:0];
                end
                default: ;
            endcase
        end

        rdata_d = rd ? rd_val : '0;
        ready_d = io_sel & (io_rstrb | (|io_wmask));
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            led_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            timer_q  <= '0;
            thresh_q <= DEBOUNCE_DEFAULT;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            led_q    <= led_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            timer_q  <= timer_d;
            thresh_q <= thresh_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
        end
    end

    assign io_rdata = rdata_q;
    assign io_ready = ready_q;
    assign LED      = led_q;

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: scoreboard bench for io_responder. Each bus access pushes
// its expected io_rdata; a negedge monitor pops and compares on io_ready.
module tb_io_responder;
    import io_pkg::*;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        io_sel;
    logic [3:0]  io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_wmask;
    logic        io_rstrb;
    logic [31:0] io_rdata;
    logic        io_ready;
    logic        SW;
    logic [7:0]  LED;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned run_len = 0;
    int unsigned last_run = 0;

    io_responder #(.DEBOUNCE_DEFAULT(16'd1000)) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .io_sel   (io_sel),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_wmask (io_wmask),
        .io_rstrb (io_rstrb),
        .io_rdata (io_rdata),
        .io_ready (io_ready),
        .SW       (SW),
        .LED      (LED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Monitor: every io_ready must match the oldest outstanding access.
    always @(negedge CLK) begin
        if (io_ready) begin
            run_len++;
            if (sb.size() == 0) begin
                chk("spurious_ready", 32'(io_ready), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.tag, io_rdata, e.val);
            end
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
    end

    // Entered and left at posedge+1; the access is accepted on the next edge.
    task automatic acc(input string tag, input logic [3:0] a, input logic [31:0] wd,
                       input logic [3:0] m, input logic r, input logic [31:0] exp);
        io_sel   = 1'b1;
        io_addr  = a;
        io_wdata = wd;
        io_wmask = m;
        io_rstrb = r;
        sb.push_back('{tag, exp});
        @(posedge CLK); #1;
    endtask

    task automatic idle(input int unsigned n);
        io_sel   = 1'b0;
        io_rstrb = 1'b0;
        io_wmask = 4'h0;
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETN   = 1'b0;
        SW       = 1'b0;
        io_sel   = 1'b1;
        io_addr  = IO_LED;
        io_wdata = 32'hFFFF_FFFF;
        io_wmask = 4'hF;
        io_rstrb = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_led",   32'(LED), 32'h0);
        chk("rst_ready", 32'(io_ready), 32'h0);
        chk("rst_rdata", io_rdata, 32'h0);
        idle(0);
        RESETN = 1'b1;
        idle(1);

        acc("rd_debounce_def", IO_DEBOUNCE, 32'h0, 4'h0, 1'b1, 32'h0000_03E8);

        acc("wr_led", IO_LED, 32'hDEAD_BEA5, 4'b0001, 1'b0, 32'h0);
        chk("led_after_wr", 32'(LED), 32'hA5);
        acc("rd_led", IO_LED, 32'h0, 4'h0, 1'b1, 32'h0000_00A5);
        acc("wr_led_m2", IO_LED, 32'h0000_7700, 4'b0010, 1'b0, 32'h0);
        acc("rd_led_m2", IO_LED, 32'h0, 4'h0, 1'b1, 32'h0000_00A5);

        acc("wr_thr4", IO_DEBOUNCE, 32'hFFFF_0004, 4'b0011, 1'b0, 32'h0);
        acc("rd_thr4", IO_DEBOUNCE, 32'h0, 4'h0, 1'b1, 32'h0000_0004);
        idle(2);

        // 3-cycle glitch is shorter than the threshold
        SW = 1'b1;
        idle(3);
        SW = 1'b0;
        idle(10);
        acc("glitch_status", IO_STATUS, 32'h0, 4'h0, 1'b1, 32'h0);

        // rise: level changes on the 6th edge after SW, visible to the 7th read
        SW = 1'b1;
        for (int i = 0; i < 6; i++) acc("rise_wait", IO_STATUS, 32'h0, 4'h0, 1'b1, 32'h0);
        acc("rise_status", IO_STATUS, 32'h0, 4'h0, 1'b1, 32'h3);

        // W1C of RISE coinciding with a FALL commit
        SW = 1'b0;
        idle(5);
        acc("w1c_rise", IO_STATUS, 32'h2, 4'b0001, 1'b0, 32'h0);
        acc("fall_status", IO_STATUS, 32'h0, 4'h0, 1'b1, 32'h4);

        // W1C of RISE coinciding with a new RISE: set wins
        SW = 1'b1;
        idle(5);
        acc("w1c_vs_rise", IO_STATUS, 32'h2, 4'b0001, 1'b0, 32'h0);
        acc("rise_kept", IO_STATUS, 32'h0, 4'h0, 1'b1, 32'h7);
        acc("w1c_fall", IO_STATUS, 32'h4, 4'b0001, 1'b0, 32'h0);
        acc("fall_cleared", IO_STATUS, 32'h0, 4'h0, 1'b1, 32'h3);

        // TIMER wrap
        acc("wr_timer", IO_TIMER, 32'hFFFF_FFFE, 4'hF, 1'b0, 32'h0);
        idle(2);
        acc("timer_wrap", IO_TIMER, 32'h0, 4'h0, 1'b1, 32'h0);
        idle(2);

        // eight back-to-back accesses
        acc("b2b_rw_led", IO_LED, 32'h0000_003C, 4'b0001, 1'b1, 32'h0000_00A5);
        acc("b2b_rd_led", IO_LED, 32'h0, 4'h0, 1'b1, 32'h0000_003C);
        acc("b2b_wr_thr", IO_DEBOUNCE, 32'hABCD_0007, 4'hF, 1'b0, 32'h0);
        acc("b2b_rd_thr", IO_DEBOUNCE, 32'h0, 4'h0, 1'b1, 32'h0000_0007);
        acc("b2b_wr_tmr", IO_TIMER, 32'h0000_1000, 4'hF, 1'b0, 32'h0);
        acc("b2b_rd_tmr0", IO_TIMER, 32'h0, 4'h0, 1'b1, 32'h0000_1000);
        acc("b2b_rd_tmr1", IO_TIMER, 32'h0, 4'h0, 1'b1, 32'h0000_1001);
        acc("b2b_rd_st", IO_STATUS, 32'h0, 4'h0, 1'b1, 32'h0000_0003);
        idle(2);
        chk("b2b_run", 32'(last_run), 32'd8);

        // io_sel low: ignored entirely
        io_sel   = 1'b0;
        io_addr  = IO_LED;
        io_wdata = 32'h0000_00FF;
        io_wmask = 4'hF;
        io_rstrb = 1'b1;
        @(posedge CLK); #1;
        chk("nosel_ready", 32'(io_ready), 32'h0);
        chk("nosel_led", 32'(LED), 32'h3C);
        idle(1);

        // threshold 0 behaves as 1: commit on the 3rd edge after SW
        acc("wr_thr0", IO_DEBOUNCE, 32'h0, 4'b0011, 1'b0, 32'h0);
        SW = 1'b0;
        for (int i = 0; i < 3; i++) acc("thr0_wait", IO_STATUS, 32'h0, 4'h0, 1'b1, 32'h3);
        acc("thr0_fall", IO_STATUS, 32'h0, 4'h0, 1'b1, 32'h6);
        idle(3);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        // reset mid-access drops it
        io_sel   = 1'b1;
        io_addr  = IO_LED;
        io_wmask = 4'h0;
        io_rstrb = 1'b1;
        #2 RESETN = 1'b0;
        @(posedge CLK); #1;
        chk("rst_mid_ready", 32'(io_ready), 32'h0);
        chk("rst_mid_led", 32'(LED), 32'h0);
        idle(1);
        RESETN = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/io_responder.md
# io_responder

Memory-mapped I/O responder that sits on the CPU's data-memory bus inside `soc`, answering accesses the address decoder routes to the I/O page. Owns the `LED` output register, a synchronised and debounced `SW` input with sticky edge flags, a programmable debounce threshold and a free-running cycle timer. The CPU is the bus initiator; this block is the responder side of that interface.

## Interface
Parameters:
- `DEBOUNCE_DEFAULT`, 16'd1000: reset value of the debounce threshold, in cycles.

Ports:
- `CLK`  in  1  system clock; all state on rising edge.
- `RESETN`  in  1  asynchronous, active-low reset.
- `io_sel`  in  1  access targets this block (from upstream address decode).
- `io_addr`  in  4  byte offset within the I/O page; bits [1:0] ignored.
- `io_wdata`  in  32  write data.
- `io_wmask`  in  4  byte write enables; any nonzero bit with `io_sel` is a write.
- `io_rstrb`  in  1  read strobe.
- `io_rdata`  out  32  read data, valid while `io_ready` is high.
- `io_ready`  out  1  one-cycle completion pulse.
- `SW`  in  1  raw asynchronous switch input.
- `LED`  out  8  LED drive, equals LED register.

## Operation
- Register map (word offsets):
  - 0x0 LED: R/W, bits [7:0]; written only when `io_wmask[0]`; upper bits read 0.
  - 0x4 STATUS: bit0 debounced SW level (RO), bit1 RISE pending, bit2 FALL pending; writing 1 to bit1/bit2 (with `io_wmask[0]`) clears it; other bits read 0.
  - 0x8 TIMER: 32-bit cycle counter, +1 every cycle, wraps 0xFFFF_FFFF -> 0; write loads per byte mask.
  - 0xC DEBOUNCE: bits [15:0] threshold, per-byte mask on bytes 0-1; upper bits read 0.
- Unmapped offsets don't exist (4-bit space fully decoded); accesses with `io_sel` low are ignored entirely, no `io_ready`.
- Read and write asserted together: write performed, read returns pre-write value.
- SW path: two-flop synchroniser -> debouncer. Counter clears whenever synchronised value equals debounced level; otherwise increments; when count reaches threshold, debounced level takes the synchronised value, counter clears, RISE or FALL flag sets. Threshold 0 behaves as 1.
- Threshold change takes effect next cycle; an in-progress count ≥ new threshold commits on the next differing cycle.
- Reset values: `LED`=0, `io_rdata`=0, `io_ready`=0, STATUS=0 (debounced level 0), TIMER=0, DEBOUNCE=`DEBOUNCE_DEFAULT`, debounce counter 0, synchroniser 0. Reset mid-access drops the access; no `io_ready` follows.

## Timing
- Access accepted in cycle N (`io_sel` and (`io_rstrb` or `io_wmask`≠0)); `io_ready` high in N+1 for exactly one cycle; `io_rdata` registered in N, valid in N+1, 0 when not a read.
- Back-to-back accesses every cycle supported; no busy state.
- Writes visible on `LED`/registers in N+1.
- Flag set and W1C clear in same cycle: set wins.
- TIMER write in cycle N: TIMER = written value in N+1, increments from there.
- STATUS read returns value held at cycle N (before any same-cycle edge event).
- SW to debounced change: 2 sync cycles + threshold cycles.

## Structure
- Package `io_pkg`: register offsets (`IO_LED`, `IO_STATUS`, `IO_TIMER`, `IO_DEBOUNCE`), STATUS bit indices, threshold width constant.
- Sub-module `sw_debouncer`: synchroniser, counter, debounced level, one-cycle `rise`/`fall` pulses; flags and bus logic stay in `io_responder`.

## Test plan
- Reset: hold `RESETN` low, drive accesses -> `LED`=0, `io_ready`=0; release, read 0xC -> 0x0000_03E8 one cycle later.
- Write 0x0 data 0xDEAD_BEA5 mask 4'b0001 -> `LED`=0xA5 next cycle; read 0x0 -> 0x0000_00A5; mask 4'b0010 write leaves 0xA5.
- Threshold 4, SW 0->1 held -> STATUS 0x3 after 2+4 cycles; SW glitch of 3 cycles -> STATUS stays 0.
- With RISE set, write 0x4 data 0x2 in same cycle as a FALL event -> STATUS reads 0x4 after; W1C coincident with new RISE -> bit1 remains 1.
- Write TIMER 0xFFFF_FFFE, read two cycles later -> 0x0000_0000 (wrap).
- Read/write every cycle for 8 cycles -> `io_ready` high 8 consecutive cycles, each `io_rdata` matching its access; `io_sel` low cycle -> no `io_ready`.
